// File: rtl/register_bank_rf.sv
// register_bank_rf: NREGS x WIDTH register file with one one-hot write port,
// two registered read ports (write-to-read bypass) and a per-register busy
// scoreboard for the issue stage.
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   we, wsel, din           write enable, one-hot register select, write data
//   re_a/raddr_a/dout_a/vld_a  read port A (1-cycle latency)
//   re_b/raddr_b/dout_b/vld_b  read port B (1-cycle latency)
//   issue_en, issue_addr    mark a register busy
//   busy                    scoreboard, bit i = write pending on register i
//   sel_err                 sticky flag for a write with a multi-hot wsel
module register_bank_rf #(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned NREGS   = 16,
    parameter bit          ZERO_R0 = 1'b0,
    localparam int unsigned AW     = $clog2(NREGS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             we,
    input  logic [NREGS-1:0] wsel,
    input  logic [WIDTH-1:0] din,
    input  logic             re_a,
    input  logic [AW-1:0]    raddr_a,
    input  logic             re_b,
    input  logic [AW-1:0]    raddr_b,
    output logic [WIDTH-1:0] dout_a,
    output logic [WIDTH-1:0] dout_b,
    output logic             vld_a,
    output logic             vld_b,
    input  logic             issue_en,
    input  logic [AW-1:0]    issue_addr,
    output logic [NREGS-1:0] busy,
    output logic             sel_err
);

    logic [WIDTH-1:0] regs_q [NREGS];
    logic [WIDTH-1:0] regs_d [NREGS];
    logic [WIDTH-1:0] dout_a_q, dout_a_d, dout_b_q, dout_b_d;
    logic             vld_a_q, vld_a_d, vld_b_q, vld_b_d;
    logic [NREGS-1:0] busy_q, busy_d;
    logic             sel_err_q, sel_err_d;

    logic             wsel_multi;
    logic             wsel_onehot;
    logic [NREGS-1:0] wr_mask;
    logic             a_ok, b_ok, i_ok;
    logic             issue_ok;
    logic [WIDTH-1:0] rd_a, rd_b;

    // Address range checks only exist when NREGS is not a power of two
    if (NREGS == (1 << AW)) begin : g_full_range
        assign a_ok = 1'b1;
        assign b_ok = 1'b1;
        assign i_ok = 1'b1;
    end else begin : g_part_range
        assign a_ok = (raddr_a    < AW'(NREGS));
        assign b_ok = (raddr_b    < AW'(NREGS));
        assign i_ok = (issue_addr < AW'(NREGS));
    end

    // x & (x-1) is nonzero exactly when two or more bits are set
    assign wsel_multi  = |(wsel & (wsel - NREGS'(1)));
    assign wsel_onehot = (wsel != '0) && !wsel_multi;

    // Mask of the register actually written this edge (empty on error/drop)
    always_comb begin
        wr_mask = '0;
        if (we && wsel_onehot) begin
            wr_mask = wsel;
        end
        if (ZERO_R0) begin
            wr_mask[0] = 1'b0;
        end
    end

    // Storage next state
    always_comb begin
        for (int i = 0; i < NREGS; i++) begin
            regs_d[i] = regs_q[i];
            if (wr_mask[i]) begin
                regs_d[i] = din;
            end
        end
    end

    // Read muxes with bypass; bypass follows wr_mask so dropped writes never forward
    always_comb begin
        rd_a = regs_q[raddr_a];
        if (!a_ok || (ZERO_R0 && (raddr_a == '0))) begin
            rd_a = '0;
        end else if (wr_mask[raddr_a]) begin
            rd_a = din;
        end

        rd_b = regs_q[raddr_b];
        if (!b_ok || (ZERO_R0 && (raddr_b == '0))) begin
            rd_b = '0;
        end else if (wr_mask[raddr_b]) begin
            rd_b = din;
        end

        dout_a_d = re_a ? rd_a : dout_a_q;
        dout_b_d = re_b ? rd_b : dout_b_q;
        vld_a_d  = re_a;
        vld_b_d  = re_b;
    end

    // Scoreboard: clear on write, then set on issue so set wins
    always_comb begin
        issue_ok = issue_en && i_ok && !(ZERO_R0 && (issue_addr == '0));
        for (int i = 0; i < NREGS; i++) begin
            busy_d[i] = (busy_q[i] & ~wr_mask[i]) |
                        (issue_ok & (issue_addr == AW'(i)));
        end
        sel_err_d = sel_err_q | (we & wsel_multi);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
            dout_a_q  <= '0;
            dout_b_q  <= '0;
            vld_a_q   <= 1'b0;
            vld_b_q   <= 1'b0;
            busy_q    <= '0;
            sel_err_q <= 1'b0;
        end else begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= regs_d[i];
            end
            dout_a_q  <= dout_a_d;
            dout_b_q  <= dout_b_d;
            vld_a_q   <= vld_a_d;
            vld_b_q   <= vld_b_d;
            busy_q    <= busy_d;
            sel_err_q <= sel_err_d;
        end
    end

    assign dout_a  = dout_a_q;
    assign dout_b  = dout_b_q;
    assign vld_a   = vld_a_q;
    assign vld_b   = vld_b_q;
    assign busy    = busy_q;
    assign sel_err = sel_err_q;

endmodule

// File: tb/tb_register_bank_rf.sv
// Directed bench for register_bank_rf: one instance with ZERO_R0=0 and one
// with ZERO_R0=1 driven by the same stimulus.
module tb_register_bank_rf;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        we;
    logic [15:0] wsel;
    logic [31:0] din;
    logic        re_a, re_b;
    logic [3:0]  raddr_a, raddr_b;
    logic        issue_en;
    logic [3:0]  issue_addr;

    logic [31:0] dout_a, dout_b, zdout_a, zdout_b;
    logic        vld_a, vld_b, zvld_a, zvld_b;
    logic [15:0] busy, zbusy;
    logic        sel_err, zsel_err;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    register_bank_rf #(.WIDTH(32), .NREGS(16), .ZERO_R0(1'b0)) dut (
        .clk(clk), .rst_n(rst_n), .we(we), .wsel(wsel), .din(din),
        .re_a(re_a), .raddr_a(raddr_a), .re_b(re_b), .raddr_b(raddr_b),
        .dout_a(dout_a), .dout_b(dout_b), .vld_a(vld_a), .vld_b(vld_b),
        .issue_en(issue_en), .issue_addr(issue_addr),
        .busy(busy), .sel_err(sel_err)
    );

    register_bank_rf #(.WIDTH(32), .NREGS(16), .ZERO_R0(1'b1)) dut_z (
        .clk(clk), .rst_n(rst_n), .we(we), .wsel(wsel), .din(din),
        .re_a(re_a), .raddr_a(raddr_a), .re_b(re_b), .raddr_b(raddr_b),
        .dout_a(zdout_a), .dout_b(zdout_b), .vld_a(zvld_a), .vld_b(zvld_b),
        .issue_en(issue_en), .issue_addr(issue_addr),
        .busy(zbusy), .sel_err(zsel_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge; outputs are then sampled 1 time unit later
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        we = 1'b0; wsel = '0; din = '0;
        re_a = 1'b0; re_b = 1'b0; raddr_a = '0; raddr_b = '0;
        issue_en = 1'b0; issue_addr = '0;
    endtask

    initial begin
        idle();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        chk("rst_dout_a", dout_a, 32'h0);
        chk("rst_dout_b", dout_b, 32'h0);
        chk("rst_vld", 32'({vld_a, vld_b}), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_sel_err", 32'(sel_err), 32'h0);

        // Write R3, read it back on port A
        we = 1'b1; wsel = 16'h0008; din = 32'hDEADBEEF;
        step();
        idle();
        re_a = 1'b1; raddr_a = 4'd3;
        step();
        chk("rd_a_r3", dout_a, 32'hDEADBEEF);
        chk("rd_a_vld", 32'(vld_a), 32'h1);
        idle();
        step();
        chk("hold_vld_a", 32'(vld_a), 32'h0);
        chk("hold_dout_a", dout_a, 32'hDEADBEEF);

        // Bypass: write R5 and read it on port B in the same cycle
        we = 1'b1; wsel = 16'h0020; din = 32'h12345678;
        re_b = 1'b1; raddr_b = 4'd5;
        step();
        chk("bypass_b", dout_b, 32'h12345678);
        chk("bypass_vld_b", 32'(vld_b), 32'h1);

        // Both ports same address
        idle();
        re_a = 1'b1; raddr_a = 4'd3; re_b = 1'b1; raddr_b = 4'd3;
        step();
        chk("same_a", dout_a, 32'hDEADBEEF);
        chk("same_b", dout_b, 32'hDEADBEEF);

        // R0 write with simultaneous read: bypass on normal DUT, zero on ZERO_R0
        idle();
        we = 1'b1; wsel = 16'h0001; din = 32'hA5A5A5A5;
        re_a = 1'b1; raddr_a = 4'd0; re_b = 1'b1; raddr_b = 4'd0;
        step();
        chk("r0_byp_norm", dout_a, 32'hA5A5A5A5);
        chk("z_r0_byp_a", zdout_a, 32'h0);
        chk("z_r0_byp_b", zdout_b, 32'h0);
        idle();
        re_a = 1'b1; raddr_a = 4'd0; re_b = 1'b1; raddr_b = 4'd0;
        issue_en = 1'b1; issue_addr = 4'd0;
        step();
        chk("r0_rd_norm", dout_b, 32'hA5A5A5A5);
        chk("z_r0_rd_a", zdout_a, 32'h0);
        chk("z_r0_rd_b", zdout_b, 32'h0);
        chk("z_r0_sel_err", 32'(zsel_err), 32'h0);
        chk("r0_busy_norm", 32'(busy), 32'h0001);
        chk("z_r0_busy", 32'(zbusy), 32'h0);

        // Write R0=0x11 clears busy[0] on the normal DUT
        idle();
        we = 1'b1; wsel = 16'h0001; din = 32'h00000011;
        step();
        chk("busy_clr0", 32'(busy), 32'h0);

        // Scoreboard on R7
        idle();
        issue_en = 1'b1; issue_addr = 4'd7;
        step();
        chk("sb_set7", 32'(busy), 32'h0080);
        we = 1'b1; wsel = 16'h0080; din = 32'h77777777;
        step();
        chk("sb_set_wins", 32'(busy), 32'h0080);
        idle();
        we = 1'b1; wsel = 16'h0080; din = 32'h77777778;
        step();
        chk("sb_clear7", 32'(busy), 32'h0);
        chk("z_sb_clear7", 32'(zbusy), 32'h0);

        // we=1 with wsel=0: no write, no error
        idle();
        we = 1'b1; wsel = 16'h0000; din = 32'hCAFEF00D;
        step();
        chk("zero_sel_no_err", 32'(sel_err), 32'h0);

        // Bad select: seed R4, then multi-hot write while reading R4/R0
        idle();
        we = 1'b1; wsel = 16'h0010; din = 32'h44444444;
        step();
        idle();
        we = 1'b1; wsel = 16'h0011; din = 32'hFFFFFFFF;
        re_a = 1'b1; raddr_a = 4'd4; re_b = 1'b1; raddr_b = 4'd0;
        step();
        chk("bad_no_byp_a", dout_a, 32'h44444444);
        chk("bad_no_byp_b", dout_b, 32'h00000011);
        chk("bad_sel_err", 32'(sel_err), 32'h1);
        chk("z_bad_sel_err", 32'(zsel_err), 32'h1);
        idle();
        repeat (10) step();
        chk("sel_err_sticky", 32'(sel_err), 32'h1);
        re_a = 1'b1; raddr_a = 4'd0; re_b = 1'b1; raddr_b = 4'd4;
        step();
        chk("bad_r0_kept", dout_a, 32'h00000011);
        chk("bad_r4_kept", dout_b, 32'h44444444);
        chk("z_r4_kept", zdout_b, 32'h44444444);

        // Asynchronous reset mid-cycle with live state
        idle();
        re_a = 1'b1; raddr_a = 4'd4; issue_en = 1'b1; issue_addr = 4'd2;
        step();
        chk("pre_rst_busy", 32'(busy), 32'h0004);
        #2 rst_n = 1'b0;
        #1;
        chk("async_dout_a", dout_a, 32'h0);
        chk("async_dout_b", dout_b, 32'h0);
        chk("async_vld", 32'({vld_a, vld_b}), 32'h0);
        chk("async_busy", 32'(busy), 32'h0);
        chk("async_sel_err", 32'(sel_err), 32'h0);
        chk("z_async_sel_err", 32'(zsel_err), 32'h0);
        step();
        rst_n = 1'b1;
        idle();
        re_a = 1'b1; raddr_a = 4'd4;
        step();
        chk("post_rst_r4", dout_a, 32'h0);
        chk("post_rst_vld", 32'(vld_a), 32'h1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
